// File: rtl/mtc_thread_scheduler_pkg.sv
// Shared types and helpers for the MTC ptcalc thread scheduler.
// Sits alongside l0mdt_dataformats_svh in the l0mdt codebase.
package mtc_thread_scheduler_pkg;

  localparam int C_NUM_THREADS_DFLT    = 3;
  localparam int C_MAX_NUM_SL_DFLT     = 3;
  localparam int C_THREAD_TIMEOUT_DFLT = 64;

  typedef enum logic {
    THR_FREE = 1'b0,
    THR_BUSY = 1'b1
  } thr_state_e;

  // The channel index must also encode the extra "no thread" value.
  function automatic int mtc_sched_ch_w(input int num_threads);
    return $clog2(num_threads + 1);
  endfunction

  function automatic int mtc_sched_no_thread(input int num_threads);
    return num_threads;
  endfunction

  localparam int MTC_SCHED_NO_THREAD = mtc_sched_no_thread(C_NUM_THREADS_DFLT);

endpackage

// File: rtl/mtc_thread_slot.sv
// One ptcalc thread: FREE/BUSY state, timeout timer, and the forced-release pulse.
module mtc_thread_slot
  import mtc_thread_scheduler_pkg::*;
#(
  parameter int c_THREAD_TIMEOUT = C_THREAD_TIMEOUT_DFLT
) (
  input  logic clock,
  input  logic rst_n,
  input  logic alloc,
  input  logic done,
  output logic busy,
  output logic timeout
);

  localparam int TW = $clog2(c_THREAD_TIMEOUT);

  thr_state_e      state, state_nxt;
  logic [TW-1:0]   timer, timer_nxt;

  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      state <= THR_FREE;
      timer <= '0;
    end else begin
      state <= state_nxt;
      timer <= timer_nxt;
    end
  end

  // A real done in the terminal cycle wins, so no error is raised for it.
  always_comb begin
    state_nxt = state;
    timer_nxt = timer;
    timeout   = 1'b0;
    case (state)
      THR_FREE: begin
        if (alloc) begin
          state_nxt = THR_BUSY;
          timer_nxt = '0;
        end
      end
      THR_BUSY: begin
        if (done) begin
          state_nxt = THR_FREE;
        end else if (timer == TW'(c_THREAD_TIMEOUT - 1)) begin
          state_nxt = THR_FREE;
          timeout   = 1'b1;
        end else begin
          timer_nxt = timer + 1'b1;
        end
      end
      default: state_nxt = THR_FREE;
    endcase
  end

  assign busy = (state == THR_BUSY);

endmodule

// File: rtl/mtc_thread_scheduler.sv
// Allocates ptcalc threads to SL candidate lanes and tracks thread occupancy.
// Optional statistics counters are enabled with MTC_THREAD_SCHED_STATS_EN.
module mtc_thread_scheduler
  import mtc_thread_scheduler_pkg::*;
#(
  parameter int c_NUM_THREADS    = C_NUM_THREADS_DFLT,
  parameter int c_MAX_NUM_SL     = C_MAX_NUM_SL_DFLT,
  parameter int c_THREAD_TIMEOUT = C_THREAD_TIMEOUT_DFLT,
  parameter int CH_W             = mtc_sched_ch_w(c_NUM_THREADS)
) (
  input  logic                                 clock,
  input  logic                                 rst_n,
  input  logic [c_MAX_NUM_SL-1:0]              slc_valid,
  input  logic [c_NUM_THREADS-1:0]             thread_done,
  output logic [c_MAX_NUM_SL-1:0]              assign_valid,
  output logic [c_MAX_NUM_SL-1:0][CH_W-1:0]    assign_ch,
  output logic [c_MAX_NUM_SL-1:0]              assign_busy,
  output logic [c_NUM_THREADS-1:0]             thread_start,
  output logic [c_NUM_THREADS-1:0]             thread_busy,
  output logic [c_NUM_THREADS-1:0]             timeout_err,
`ifdef MTC_THREAD_SCHED_STATS_EN
  output logic [31:0]                          alloc_cnt,
  output logic [31:0]                          timeout_cnt,
  output logic [CH_W-1:0]                      peak_busy,
`endif
  output logic [15:0]                          drop_cnt
);

  localparam logic [CH_W-1:0] NO_THREAD = CH_W'(mtc_sched_no_thread(c_NUM_THREADS));
  localparam int DW = $clog2(c_MAX_NUM_SL + 1);

  logic [c_NUM_THREADS-1:0]           taken;
  logic [c_NUM_THREADS-1:0]           alloc_vec;
  logic [c_MAX_NUM_SL-1:0][CH_W-1:0]  lane_ch_nxt;
  logic [c_MAX_NUM_SL-1:0]            lane_hit_nxt;
  logic [DW-1:0]                      ndrop;
  logic [16:0]                        drop_sum;

  for (genvar t = 0; t < c_NUM_THREADS; t++) begin : g_slot
    mtc_thread_slot #(
      .c_THREAD_TIMEOUT(c_THREAD_TIMEOUT)
    ) u_slot (
      .clock   (clock),
      .rst_n   (rst_n),
      .alloc   (alloc_vec[t]),
      .done    (thread_done[t]),
      .busy    (thread_busy[t]),
      .timeout (timeout_err[t])
    );
  end

  // Only threads free at the start of the cycle are eligible, so a thread
  // released this cycle is naturally held back until the next one.
  always_comb begin
    taken        = thread_busy;
    alloc_vec    = '0;
    ndrop        = '0;
    lane_ch_nxt  = '0;
    lane_hit_nxt = '0;
    for (int l = 0; l < c_MAX_NUM_SL; l++) begin
      lane_ch_nxt[l] = NO_THREAD;
      if (slc_valid[l]) begin
        for (int t = 0; t < c_NUM_THREADS; t++) begin
          if (!lane_hit_nxt[l] && !taken[t]) begin
            lane_ch_nxt[l]  = CH_W'(t);
            lane_hit_nxt[l] = 1'b1;
            taken[t]        = 1'b1;
            alloc_vec[t]    = 1'b1;
          end
        end
        if (!lane_hit_nxt[l]) ndrop = ndrop + 1'b1;
      end
    end
  end

  assign drop_sum = {1'b0, drop_cnt} + 17'(ndrop);

  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      assign_valid <= '0;
      assign_busy  <= '0;
      thread_start <= '0;
      drop_cnt     <= '0;
      for (int l = 0; l < c_MAX_NUM_SL; l++) assign_ch[l] <= NO_THREAD;
    end else begin
      assign_valid <= slc_valid;
      assign_busy  <= lane_hit_nxt;
      assign_ch    <= lane_ch_nxt;
      thread_start <= alloc_vec;
      drop_cnt     <= drop_sum[16] ? 16'hFFFF : drop_sum[15:0];
    end
  end

`ifdef MTC_THREAD_SCHED_STATS_EN
  logic [32:0]     alloc_sum;
  logic [32:0]     timeout_sum;
  logic [CH_W-1:0] busy_pop;

  assign alloc_sum   = {1'b0, alloc_cnt} + 33'($countones(alloc_vec));
  assign timeout_sum = {1'b0, timeout_cnt} + 33'($countones(timeout_err));
  assign busy_pop    = CH_W'($countones(thread_busy));

  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      alloc_cnt   <= '0;
      timeout_cnt <= '0;
      peak_busy   <= '0;
    end else begin
      alloc_cnt   <= alloc_sum[32] ? 32'hFFFF_FFFF : alloc_sum[31:0];
      timeout_cnt <= timeout_sum[32] ? 32'hFFFF_FFFF : timeout_sum[31:0];
      if (busy_pop > peak_busy) peak_busy <= busy_pop;
    end
  end
`endif

endmodule

// File: tb/tb_mtc_thread_scheduler.sv
// Directed self-checking bench for mtc_thread_scheduler (3 threads, 3 lanes, timeout 64).
// Build with MTC_THREAD_SCHED_STATS_EN defined to also cover the statistics ports.
module tb_mtc_thread_scheduler;

  logic            clock;
  logic            rst_n;
  logic [2:0]      slc_valid;
  logic [2:0]      thread_done;
  logic [2:0]      assign_valid;
  logic [2:0][1:0] assign_ch;
  logic [2:0]      assign_busy;
  logic [2:0]      thread_start;
  logic [2:0]      thread_busy;
  logic [2:0]      timeout_err;
  logic [15:0]     drop_cnt;
`ifdef MTC_THREAD_SCHED_STATS_EN
  logic [31:0]     alloc_cnt;
  logic [31:0]     timeout_cnt;
  logic [1:0]      peak_busy;
`endif

  int checks = 0;
  int errors = 0;

  mtc_thread_scheduler dut (
    .clock        (clock),
    .rst_n        (rst_n),
    .slc_valid    (slc_valid),
    .thread_done  (thread_done),
    .assign_valid (assign_valid),
    .assign_ch    (assign_ch),
    .assign_busy  (assign_busy),
    .thread_start (thread_start),
    .thread_busy  (thread_busy),
    .timeout_err  (timeout_err),
`ifdef MTC_THREAD_SCHED_STATS_EN
    .alloc_cnt    (alloc_cnt),
    .timeout_cnt  (timeout_cnt),
    .peak_busy    (peak_busy),
`endif
    .drop_cnt     (drop_cnt)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Drive one cycle of inputs, then sample the registered result 1ns after the edge.
  task automatic applyStimulus(input logic [2:0] valid, input logic [2:0] done);
    slc_valid   = valid;
    thread_done = done;
    @(posedge clock);
    #1;
    slc_valid   = '0;
    thread_done = '0;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected)
      else begin
        errors++;
        $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
      end
  endtask

  initial begin
    slc_valid   = '0;
    thread_done = '0;
    rst_n       = 1'b0;
    #12;
    checkOutput("rst_assign_ch",    32'(assign_ch),    32'h3F);
    checkOutput("rst_assign_valid", 32'(assign_valid), 32'h0);
    checkOutput("rst_thread_busy",  32'(thread_busy),  32'h0);
    checkOutput("rst_drop_cnt",     32'(drop_cnt),     32'h0);
    checkOutput("rst_thread_start", 32'(thread_start), 32'h0);
    rst_n = 1'b1;

    // All three lanes valid, all threads free: lanes map to threads 0,1,2.
    applyStimulus(3'b111, 3'b000);
    checkOutput("all_assign_ch",    32'(assign_ch),    32'h24);
    checkOutput("all_assign_busy",  32'(assign_busy),  32'h7);
    checkOutput("all_assign_valid", 32'(assign_valid), 32'h7);
    checkOutput("all_thread_start", 32'(thread_start), 32'h7);
    checkOutput("all_thread_busy",  32'(thread_busy),  32'h7);
`ifdef MTC_THREAD_SCHED_STATS_EN
    checkOutput("all_alloc_cnt",    alloc_cnt,         32'd3);
`endif

    // Release thread 1 only.
    applyStimulus(3'b000, 3'b010);
    checkOutput("rel1_thread_busy",  32'(thread_busy),  32'h5);
    checkOutput("rel1_thread_start", 32'(thread_start), 32'h0);
    checkOutput("rel1_assign_ch",    32'(assign_ch),    32'h3F);

    // Threads 0 and 2 busy, lanes 0 and 2 request: lane0 -> 1, lane2 dropped.
    applyStimulus(3'b101, 3'b000);
    checkOutput("part_assign_ch",    32'(assign_ch),    32'h3D);
    checkOutput("part_assign_busy",  32'(assign_busy),  32'h1);
    checkOutput("part_assign_valid", 32'(assign_valid), 32'h5);
    checkOutput("part_drop_cnt",     32'(drop_cnt),     32'd1);
    checkOutput("part_thread_start", 32'(thread_start), 32'h2);
    checkOutput("part_thread_busy",  32'(thread_busy),  32'h7);

    // Done on thread 1 in the same cycle as a request: not allocatable yet.
    applyStimulus(3'b001, 3'b010);
    checkOutput("same_assign_ch",   32'(assign_ch),   32'h3F);
    checkOutput("same_assign_busy", 32'(assign_busy), 32'h0);
    checkOutput("same_drop_cnt",    32'(drop_cnt),    32'd2);
    checkOutput("same_thread_busy", 32'(thread_busy), 32'h5);
    applyStimulus(3'b001, 3'b000);
    checkOutput("next_assign_ch",   32'(assign_ch),   32'h3D);
    checkOutput("next_assign_busy", 32'(assign_busy), 32'h1);
    checkOutput("next_thread_busy", 32'(thread_busy), 32'h7);

    // Free everything, then let thread 0 run into its timeout.
    applyStimulus(3'b000, 3'b111);
    checkOutput("freeall_thread_busy", 32'(thread_busy), 32'h0);
    applyStimulus(3'b001, 3'b000);
    checkOutput("to_alloc_ch",   32'(assign_ch),   32'h3C);
    checkOutput("to_alloc_busy", 32'(thread_busy), 32'h1);
    for (int i = 0; i < 62; i++) applyStimulus(3'b000, 3'b000);
    checkOutput("to_early_err",  32'(timeout_err), 32'h0);
    applyStimulus(3'b000, 3'b000);
    checkOutput("to_pulse_err",  32'(timeout_err), 32'h1);
    checkOutput("to_pulse_busy", 32'(thread_busy), 32'h1);
    applyStimulus(3'b000, 3'b000);
    checkOutput("to_after_err",  32'(timeout_err), 32'h0);
    checkOutput("to_after_busy", 32'(thread_busy), 32'h0);
`ifdef MTC_THREAD_SCHED_STATS_EN
    checkOutput("to_timeout_cnt", timeout_cnt, 32'd1);
    checkOutput("to_peak_busy",   32'(peak_busy), 32'd3);
`endif
    applyStimulus(3'b001, 3'b000);
    checkOutput("to_realloc_ch",    32'(assign_ch),    32'h3C);
    checkOutput("to_realloc_start", 32'(thread_start), 32'h1);

    // Saturate the drop counter with a long stretch of full demand.
    slc_valid = 3'b111;
    for (int i = 0; i < 30000; i++) @(posedge clock);
    #1;
    checkOutput("sat_drop_cnt", 32'(drop_cnt), 32'hFFFF);
    applyStimulus(3'b111, 3'b000);
    checkOutput("sat_hold_cnt", 32'(drop_cnt), 32'hFFFF);
    checkOutput("sat_busy",     32'(thread_busy), 32'h7);

    // Asynchronous reset in mid-cycle with threads busy.
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("arst_assign_ch",    32'(assign_ch),    32'h3F);
    checkOutput("arst_thread_busy",  32'(thread_busy),  32'h0);
    checkOutput("arst_drop_cnt",     32'(drop_cnt),     32'h0);
    checkOutput("arst_assign_valid", 32'(assign_valid), 32'h0);
`ifdef MTC_THREAD_SCHED_STATS_EN
    checkOutput("arst_alloc_cnt",    alloc_cnt,         32'd0);
`endif
    rst_n = 1'b1;
    applyStimulus(3'b001, 3'b000);
    checkOutput("post_assign_ch",   32'(assign_ch),   32'h3C);
    checkOutput("post_thread_busy", 32'(thread_busy), 32'h1);
`ifdef MTC_THREAD_SCHED_STATS_EN
    checkOutput("post_alloc_cnt",   alloc_cnt,        32'd1);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
